// File: rtl/brs_if.sv
// Request/result/lookup bundle between the branch resolve unit (slave) and
// its EX-stage driver and PC-redirect consumer (master).
interface brs_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_i;
    logic             ready_o;
    logic [5:0]       opcode_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] pc_i;
    logic [15:0]      imm_i;
    logic             pred_taken_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic             is_branch_o;
    logic             taken_o;
    logic [WIDTH-1:0] next_pc_o;
    logic             mispredict_o;
    logic [WIDTH-1:0] lookup_pc_i;
    logic             lookup_taken_o;

    modport slave (
        input  valid_i, opcode_i, src1_i, src2_i, pc_i, imm_i, pred_taken_i,
               res_ready_i, lookup_pc_i,
        output ready_o, res_valid_o, is_branch_o, taken_o, next_pc_o,
               mispredict_o, lookup_taken_o
    );

    modport master (
        output valid_i, opcode_i, src1_i, src2_i, pc_i, imm_i, pred_taken_i,
               res_ready_i, lookup_pc_i,
        input  ready_o, res_valid_o, is_branch_o, taken_o, next_pc_o,
               mispredict_o, lookup_taken_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition evaluation, target computation,
// mispredict flagging and 2-bit saturating BHT training, with a registered result.
module branch_resolve_unit #(
    parameter int WIDTH      = 32,
    parameter int BHT_DEPTH  = 16,
    parameter bit SIGNED_CMP = 1'b1
) (
    input logic  clk_i,
    input logic  rst_i,
    brs_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int EXT_W = (WIDTH > 18) ? WIDTH : 18;

    typedef enum logic [5:0] {
        OP_BGEZ = 6'b000001,
        OP_BEQ  = 6'b000100,
        OP_BNE  = 6'b000101,
        OP_BLEZ = 6'b000110,
        OP_BGT  = 6'b000111
    } br_op_e;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_RESET = 2'd1;
    localparam ctr_t CTR_MAX   = 2'd3;
    localparam ctr_t CTR_MIN   = 2'd0;

    logic             res_valid_q;
    logic             is_branch_q;
    logic             taken_q;
    logic             mispredict_q;
    logic [WIDTH-1:0] next_pc_q;
    ctr_t             bht_q [BHT_DEPTH];

    logic             accept;
    logic             is_branch_d;
    logic             taken_d;
    logic             mispredict_d;
    logic [WIDTH-1:0] next_pc_d;
    logic             eq;
    logic             ge;
    logic             gt;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;
    logic [17:0]      off18;
    logic [EXT_W-1:0] off_ext;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lkp_idx;
    ctr_t             upd_ctr_d;

    assign bus.ready_o = !res_valid_q || bus.res_ready_i;
    assign accept      = bus.valid_i && bus.ready_o;

    assign eq = (bus.src1_i == bus.src2_i);
    if (SIGNED_CMP) begin : g_signed_cmp
        assign ge = ($signed(bus.src1_i) >= $signed(bus.src2_i));
        assign gt = ($signed(bus.src1_i) >  $signed(bus.src2_i));
    end else begin : g_unsigned_cmp
        assign ge = (bus.src1_i >= bus.src2_i);
        assign gt = (bus.src1_i >  bus.src2_i);
    end

    // Word offset scaled to bytes, sign-extended (or truncated) to WIDTH; sums wrap.
    assign off18    = {bus.imm_i, 2'b00};
    assign off_ext  = EXT_W'($signed(off18));
    assign pc_plus4 = bus.pc_i + WIDTH'(4);
    assign target   = pc_plus4 + off_ext[WIDTH-1:0];

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        is_branch_d = 1'b1;
        taken_d     = 1'b0;
        case (bus.opcode_i)
            OP_BEQ:  taken_d = eq;
            OP_BNE:  taken_d = !eq;
            OP_BGEZ: taken_d = ge;
            OP_BGT:  taken_d = gt;
            OP_BLEZ: taken_d = !gt;
            default: is_branch_d = 1'b0;
        endcase
        next_pc_d    = taken_d ? target : pc_plus4;
        mispredict_d = is_branch_d && (taken_d != bus.pred_taken_i);
    end

    assign upd_idx = bus.pc_i[IDX_W+1:2];
    assign lkp_idx = bus.lookup_pc_i[IDX_W+1:2];

    always_comb begin
        upd_ctr_d = bht_q[upd_idx];
        if (taken_d && (bht_q[upd_idx] != CTR_MAX)) begin
            upd_ctr_d = bht_q[upd_idx] + 2'd1;
        end else if (!taken_d && (bht_q[upd_idx] != CTR_MIN)) begin
            upd_ctr_d = bht_q[upd_idx] - 2'd1;
        end
    end

    // Read of the live array: a same-cycle write is only visible after the edge.
    assign bus.lookup_taken_o = bht_q[lkp_idx][1];

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            res_valid_q  <= 1'b0;
            is_branch_q  <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            next_pc_q    <= '0;
            // NOTE: the BHT is a small flop array with a defined weak-NT start, so it is reset like any register.
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_RESET;
            end
        end else begin
            if (accept) begin
                res_valid_q  <= 1'b1;
                is_branch_q  <= is_branch_d;
                taken_q      <= taken_d;
                mispredict_q <= mispredict_d;
                next_pc_q    <= next_pc_d;
                if (is_branch_d) begin
                    bht_q[upd_idx] <= upd_ctr_d;
                end
            end else if (bus.res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.res_valid_o  = res_valid_q;
    assign bus.is_branch_o  = is_branch_q;
    assign bus.taken_o      = taken_q;
    assign bus.mispredict_o = mispredict_q;
    assign bus.next_pc_o    = next_pc_q;

    logic unused_lookup_bits;
    assign unused_lookup_bits = ^{bus.lookup_pc_i[WIDTH-1:IDX_W+2], bus.lookup_pc_i[1:0]};
endmodule
